// File: rtl/mips_icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package mips_icache_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_e;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int ADDR_W          = 30;
    localparam int BLOCK_ADDR_W    = 28;
    localparam int OFFSET_W        = 2;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays with one fill port and a combinational lookup.
// Zero-cycle read, fill lands at the clock edge; no backpressure (fill is always accepted).
module icache_line_store
    import mips_icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = $clog2(NUM_BLOCKS),
    parameter int TAG_W      = BLOCK_ADDR_W - INDEX_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fill_vld_i,
    input  logic [INDEX_W-1:0] fill_idx_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_dat_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    input  logic [OFFSET_W-1:0] rd_off_i,
    output logic               hit_o,
    output logic [WORD_W-1:0]  rd_dat_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] data_q [NUM_BLOCKS];

    always_comb begin
        valid_d = valid_q;
        if (fill_vld_i) begin
            valid_d[fill_idx_i] = 1'b1;
        end
    end

    // Reset wins over a coincident fill, so an aborted refill never marks the line valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_vld_i && !rst_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_dat_i;
        end
    end

    assign hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_dat_o = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/mips_icache.sv
// Direct-mapped read-only I-cache: hits answer in the same cycle, misses refill a 128-bit block.
// Stalls the fetch stage (combinational proc_stall) until the block arrives from memory.
module mips_icache
    import mips_icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [WORD_W-1:0]       proc_wdata,
    output logic                    proc_stall,
    output logic [WORD_W-1:0]       proc_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [BLOCK_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]      mem_wdata,
    input  logic [BLOCK_W-1:0]      mem_rdata,
    input  logic                    mem_ready
);

    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = BLOCK_ADDR_W - INDEX_W;

    state_e                  state_q;
    logic                    mem_read_q;
    logic [BLOCK_ADDR_W-1:0] miss_addr_q;

    logic                    hit;
    logic [WORD_W-1:0]       rd_word;
    logic                    fill_vld;
    logic                    unused_inputs;

    icache_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk_i      (clk),
        .rst_i      (rst),
        .fill_vld_i (fill_vld),
        .fill_idx_i (miss_addr_q[INDEX_W-1:0]),
        .fill_tag_i (miss_addr_q[BLOCK_ADDR_W-1:INDEX_W]),
        .fill_dat_i (mem_rdata),
        .rd_idx_i   (proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W]),
        .rd_tag_i   (proc_addr[ADDR_W-1:INDEX_W+OFFSET_W]),
        .rd_off_i   (proc_addr[OFFSET_W-1:0]),
        .hit_o      (hit),
        .rd_dat_o   (rd_word)
    );

    // mem_ready outside FETCH is a stray pulse and must not touch the arrays.
    assign fill_vld = (state_q == S_FETCH) && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_read_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (proc_read && !hit) begin
                        miss_addr_q <= proc_addr[ADDR_W-1:OFFSET_W];
                        mem_read_q  <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        mem_read_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    mem_read_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign proc_stall = proc_read && ((state_q != S_IDLE) || !hit);
    assign proc_rdata = hit ? rd_word : '0;

    assign mem_read  = mem_read_q;
    assign mem_addr  = miss_addr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    // The write side of the fetch interface is accepted but carries no meaning here.
    assign unused_inputs = ^{proc_write, proc_wdata};

endmodule

// File: tb/tb_mips_icache.sv
// Directed bench for mips_icache: miss/refill, hits, conflicts, long latency, reset abort, writes.
module tb_mips_icache;

    logic         clk;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int vectors;
    int miscompares;

    mips_icache #(.NUM_BLOCKS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        proc_read   = 1'b0;
        proc_write  = 1'b0;
        proc_addr   = '0;
        proc_wdata  = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("reset_mem_read", {127'b0, mem_read}, 128'h0);
        chk("reset_stall", {127'b0, proc_stall}, 128'h0);
        chk("reset_mem_write", {127'b0, mem_write}, 128'h0);
        chk("reset_mem_wdata", mem_wdata, 128'h0);

        // cold miss on word address 5 (index 1, offset 1)
        proc_read = 1'b1;
        proc_addr = 30'h0000_0005;
        settle();
        chk("cold_stall", {127'b0, proc_stall}, 128'h1);
        chk("cold_rdata", {96'b0, proc_rdata}, 128'h0);
        tick();
        chk("cold_mem_read", {127'b0, mem_read}, 128'h1);
        chk("cold_mem_addr", {100'b0, mem_addr}, 128'h1);
        tick();
        tick();
        tick();
        chk("cold_wait_mem_read", {127'b0, mem_read}, 128'h1);
        mem_ready = 1'b1;
        mem_rdata = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        settle();
        chk("cold_fill_cycle_stall", {127'b0, proc_stall}, 128'h1);
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        settle();
        chk("cold_after_stall", {127'b0, proc_stall}, 128'h0);
        chk("cold_after_rdata", {96'b0, proc_rdata}, 128'hBBBB);
        chk("cold_after_mem_read", {127'b0, mem_read}, 128'h0);

        // hits on the remaining words of the line
        proc_addr = 30'h4;
        settle();
        chk("hit4_stall", {127'b0, proc_stall}, 128'h0);
        chk("hit4_rdata", {96'b0, proc_rdata}, 128'hAAAA);
        tick();
        proc_addr = 30'h6;
        settle();
        chk("hit6_rdata", {96'b0, proc_rdata}, 128'hCCCC);
        tick();
        proc_addr = 30'h7;
        settle();
        chk("hit7_stall", {127'b0, proc_stall}, 128'h0);
        chk("hit7_rdata", {96'b0, proc_rdata}, 128'hDDDD);
        chk("hit7_mem_read", {127'b0, mem_read}, 128'h0);

        // miss on 0x20 (index 0, tag 1) with a 20-cycle memory latency
        proc_addr = 30'h20;
        settle();
        chk("m20_stall", {127'b0, proc_stall}, 128'h1);
        tick();
        for (int i = 0; i < 20; i++) begin
            proc_addr = (i % 2 == 0) ? 30'h40 : 30'h5;
            settle();
            chk("long_mem_read", {127'b0, mem_read}, 128'h1);
            chk("long_mem_addr", {100'b0, mem_addr}, 128'h8);
            chk("long_stall", {127'b0, proc_stall}, 128'h1);
            tick();
        end
        proc_addr = 30'h20;
        mem_ready = 1'b1;
        mem_rdata = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
        tick();
        mem_ready = 1'b0;
        settle();
        chk("m20_hit_stall", {127'b0, proc_stall}, 128'h0);
        chk("m20_hit_rdata", {96'b0, proc_rdata}, 128'h1111_0000);

        // conflict: 0x0 shares index 0 with a different tag
        proc_addr = 30'h0;
        settle();
        chk("conf0_stall", {127'b0, proc_stall}, 128'h1);
        tick();
        chk("conf0_mem_addr", {100'b0, mem_addr}, 128'h0);
        mem_ready = 1'b1;
        mem_rdata = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
        tick();
        mem_ready = 1'b0;
        settle();
        chk("conf0_hit_rdata", {96'b0, proc_rdata}, 128'h2222_0000);
        chk("conf0_hit_stall", {127'b0, proc_stall}, 128'h0);
        proc_addr = 30'h20;
        settle();
        chk("conf20_evicted_stall", {127'b0, proc_stall}, 128'h1);
        chk("conf20_evicted_rdata", {96'b0, proc_rdata}, 128'h0);
        proc_addr = 30'h5;
        settle();
        chk("index1_kept_rdata", {96'b0, proc_rdata}, 128'hBBBB);
        proc_read = 1'b0;
        proc_addr = 30'h20;
        settle();
        chk("noread_stall", {127'b0, proc_stall}, 128'h0);
        tick();
        chk("noread_mem_read", {127'b0, mem_read}, 128'h0);

        // proc_read drops mid-fetch; the fill still lands (0x48: index 2, tag 2)
        proc_read = 1'b1;
        proc_addr = 30'h48;
        tick();
        chk("drop_mem_addr", {100'b0, mem_addr}, 128'h12);
        proc_read = 1'b0;
        tick();
        chk("drop_mem_read", {127'b0, mem_read}, 128'h1);
        mem_ready = 1'b1;
        mem_rdata = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        tick();
        mem_ready = 1'b0;
        proc_read = 1'b1;
        proc_addr = 30'h4A;
        settle();
        chk("drop_hit_stall", {127'b0, proc_stall}, 128'h0);
        chk("drop_hit_rdata", {96'b0, proc_rdata}, 128'h3333_0002);

        // stray mem_ready in IDLE is ignored (0x6C: index 3, tag 3)
        proc_read = 1'b0;
        proc_addr = 30'h6C;
        mem_ready = 1'b1;
        mem_rdata = {4{32'h4444_4444}};
        tick();
        mem_ready = 1'b0;
        chk("stray_mem_read", {127'b0, mem_read}, 128'h0);
        proc_read = 1'b1;
        settle();
        chk("stray_still_miss", {127'b0, proc_stall}, 128'h1);

        // writes have no effect
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_wdata = 32'hDEAD_BEEF;
        settle();
        chk("write_stall", {127'b0, proc_stall}, 128'h0);
        tick();
        tick();
        chk("write_mem_read", {127'b0, mem_read}, 128'h0);
        chk("write_mem_write", {127'b0, mem_write}, 128'h0);
        proc_write = 1'b0;
        proc_read  = 1'b1;
        settle();
        chk("write_no_valid", {127'b0, proc_stall}, 128'h1);
        proc_addr = 30'h4A;
        settle();
        chk("write_keep_hit", {96'b0, proc_rdata}, 128'h3333_0002);

        // reset coinciding with mem_ready aborts the fill (0x6C miss)
        proc_addr = 30'h6C;
        tick();
        chk("rstf_mem_read", {127'b0, mem_read}, 128'h1);
        chk("rstf_mem_addr", {100'b0, mem_addr}, 128'h1B);
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = {4{32'h5555_5555}};
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        settle();
        chk("rstf_mem_read_off", {127'b0, mem_read}, 128'h0);
        chk("rstf_reread_miss", {127'b0, proc_stall}, 128'h1);
        chk("rstf_reread_rdata", {96'b0, proc_rdata}, 128'h0);
        proc_addr = 30'h5;
        settle();
        chk("rstf_valid_cleared", {127'b0, proc_stall}, 128'h1);
        proc_read = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
